// File: rtl/ct_spsram_2048x32_ctrl.sv
// Access controller for the 2048x32 single-port SRAM macro: valid/ready requests to
// active-low macro pins, optional post-reset array fill, 2-entry read response buffer.
module ct_spsram_2048x32_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 11,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                      forever_cpuclk,
  input  logic                      cpurst_b,
  input  logic                      req_vld,
  output logic                      req_rdy,
  input  logic                      req_wr,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_be,
  output logic                      rsp_vld,
  input  logic                      rsp_rdy,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      init_done,
  output logic                      ram_cen,
  output logic                      ram_gwen,
  output logic [DATA_WIDTH-1:0]     ram_wen,
  output logic [ADDR_WIDTH-1:0]     ram_a,
  output logic [DATA_WIDTH-1:0]     ram_d,
  input  logic [DATA_WIDTH-1:0]     ram_q
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned OCC_W = 3;
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(2);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [2];

  logic                  push;
  logic                  pop;
  logic                  req_fire;
  logic [OCC_W-1:0]      occ_after_pop;
  logic [DATA_WIDTH-1:0] be_wen_n;

  assign push          = rd_inflight_q;
  assign rsp_vld       = cpurst_b & (fifo_cnt_q != '0);
  assign pop           = rsp_vld & rsp_rdy;
  assign rsp_data      = fifo_mem_q[rd_ptr_q];
  assign init_done     = cpurst_b & init_done_q;
  assign req_fire      = req_vld & req_rdy;
  // Read credit: buffered + in-flight reads, minus the entry leaving this cycle.
  assign occ_after_pop = OCC_W'(fifo_cnt_q) + OCC_W'(rd_inflight_q) - OCC_W'(pop);

  always_comb begin
    be_wen_n = '1;
    for (int unsigned i = 0; i < BE_W; i++) begin
      be_wen_n[8*i +: 8] = {8{~req_be[i]}};
    end
  end

  // Next state and macro drive; the macro samples these pins on the same edge.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    req_rdy    = 1'b0;
    ram_cen    = 1'b1;
    ram_gwen   = 1'b1;
    ram_wen    = '1;
    ram_a      = '0;
    ram_d      = '0;
    if (cpurst_b) begin
      case (state_q)
        ST_INIT: begin
          ram_cen    = 1'b0;
          ram_gwen   = 1'b0;
          ram_wen    = '0;
          ram_a      = fill_cnt_q;
          ram_d      = INIT_VAL;
          fill_cnt_d = fill_cnt_q + ADDR_WIDTH'(1);
          if (&fill_cnt_q) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          req_rdy = req_wr | (occ_after_pop < OCC_W'(2));
          if (req_vld & req_rdy) begin
            ram_cen = 1'b0;
            ram_a   = req_addr;
            if (req_wr) begin
              ram_gwen = 1'b0;
              ram_wen  = be_wen_n;
              ram_d    = req_wdata;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    init_done_d   = (state_d == ST_RUN);
    rd_inflight_d = req_fire & ~req_wr;
    fifo_cnt_d    = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d      = wr_ptr_q ^ push;
    rd_ptr_d      = rd_ptr_q ^ pop;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q       <= INIT_EN ? ST_INIT : ST_RUN;
      fill_cnt_q    <= '0;
      init_done_q   <= 1'b0;
      rd_inflight_q <= 1'b0;
      fifo_cnt_q    <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      init_done_q   <= init_done_d;
      rd_inflight_q <= rd_inflight_d;
      fifo_cnt_q    <= fifo_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Q is valid exactly one cycle after the read access.
  always_ff @(posedge forever_cpuclk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= ram_q;
    end
  end

  a_no_overflow: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    !(push && (fifo_cnt_q == FIFO_FULL)));

endmodule

// File: tb/tb_ct_spsram_2048x32_ctrl.sv
// Bench for ct_spsram_2048x32_ctrl: vector table, corner sequences and random traffic
// against a word-array/queue reference model, with a behavioural SRAM macro per DUT.
module tb_ct_spsram_2048x32_ctrl;

  localparam int unsigned DEPTH = 2048;
  localparam logic [31:0] IVAL  = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main DUT (fill enabled)
  logic        req_vld, req_rdy, req_wr, rsp_vld, rsp_rdy, init_done;
  logic [10:0] req_addr, ram_a;
  logic [31:0] req_wdata, rsp_data, ram_wen, ram_d, ram_q;
  logic [3:0]  req_be;
  logic        ram_cen, ram_gwen;

  // Second DUT (fill disabled)
  logic        req_vld0, req_rdy0, req_wr0, rsp_vld0, rsp_rdy0, init_done0;
  logic [10:0] req_addr0, ram_a0;
  logic [31:0] req_wdata0, rsp_data0, ram_wen0, ram_d0, ram_q0;
  logic [3:0]  req_be0;
  logic        ram_cen0, ram_gwen0;

  ct_spsram_2048x32_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .INIT_EN(1'b1),
                           .INIT_VAL(IVAL)) dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .init_done(init_done),
    .ram_cen(ram_cen), .ram_gwen(ram_gwen), .ram_wen(ram_wen), .ram_a(ram_a),
    .ram_d(ram_d), .ram_q(ram_q));

  ct_spsram_2048x32_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .INIT_EN(1'b0),
                           .INIT_VAL(32'h0)) dut0 (
    .forever_cpuclk(clk), .cpurst_b(rst_n),
    .req_vld(req_vld0), .req_rdy(req_rdy0), .req_wr(req_wr0), .req_addr(req_addr0),
    .req_wdata(req_wdata0), .req_be(req_be0),
    .rsp_vld(rsp_vld0), .rsp_rdy(rsp_rdy0), .rsp_data(rsp_data0), .init_done(init_done0),
    .ram_cen(ram_cen0), .ram_gwen(ram_gwen0), .ram_wen(ram_wen0), .ram_a(ram_a0),
    .ram_d(ram_d0), .ram_q(ram_q0));

  // Behavioural macros: per-bit active-low write mask, Q registered on read.
  logic [31:0] mem  [DEPTH];
  logic [31:0] mem0 [DEPTH];
  always @(posedge clk) begin
    if (!ram_cen) begin
      if (!ram_gwen) mem[ram_a] <= (mem[ram_a] & ram_wen) | (ram_d & ~ram_wen);
      else           ram_q <= mem[ram_a];
    end
    if (!ram_cen0) begin
      if (!ram_gwen0) mem0[ram_a0] <= (mem0[ram_a0] & ram_wen0) | (ram_d0 & ~ram_wen0);
      else            ram_q0 <= mem0[ram_a0];
    end
  end

  int checks = 0;
  int fails  = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];

  typedef struct {
    bit          wr;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;   // read data for reads, ram_wen at accept for writes
  } vec_t;
  vec_t vt [8];

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic logic [31:0] stream_val(input int i);
    return 32'hC0DE0000 + 32'(i) * 32'h00000101;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference model: word array plus queue of outstanding read results.
  task automatic monitor();
    bit acc, pop;
    int occ;
    if (!rst_n) begin
      exp_q.delete();
      foreach (ref_mem[i]) ref_mem[i] = IVAL;
      return;
    end
    acc = req_vld && req_rdy;
    pop = rsp_vld && rsp_rdy;
    if (init_done) begin
      occ = exp_q.size() - (pop ? 1 : 0);
      chk("req_rdy", req_rdy, (req_wr || occ < 2));
      chk("macro_pins", {ram_cen, ram_gwen, ram_a, ram_wen},
          {!acc, !(acc && req_wr), (acc ? req_addr : 11'h0),
           ((acc && req_wr) ? ~be_mask(req_be) : 32'hFFFFFFFF)});
      if (!(acc && !req_wr)) chk("macro_d", ram_d, (acc ? req_wdata : 32'h0));
    end else begin
      chk("req_rdy_during_init", req_rdy, 1'b0);
    end
    if (pop) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rsp_spurious act=%0h exp=none", rsp_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rsp_data !== e) begin
          fails++;
          $display("FAIL rsp_data act=%0h exp=%0h", rsp_data, e);
        end
      end
    end
    if (acc) begin
      if (req_wr) ref_mem[req_addr] = (ref_mem[req_addr] & ~be_mask(req_be))
                                    | (req_wdata & be_mask(req_be));
      else        exp_q.push_back(ref_mem[req_addr]);
    end
  endtask

  task automatic sample();  @(negedge clk); monitor(); endtask
  task automatic advance(); @(posedge clk); #1; endtask
  task automatic tick();    sample(); advance(); endtask

  task automatic check_idle(input string nm);
    chk(nm, {req_rdy, rsp_vld, init_done, ram_cen, ram_gwen, ram_wen, ram_a, ram_d},
        {3'b000, 2'b11, 32'hFFFFFFFF, 11'h0, 32'h0});
  endtask

  task automatic do_req(input bit wr, input logic [10:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] wen, output bit ok);
    ok = 0; wen = '0;
    req_vld = 1; req_wr = wr; req_addr = a; req_wdata = d; req_be = be;
    for (int w = 0; w < 20 && !ok; w++) begin
      sample();
      if (req_rdy) begin ok = 1; wen = ram_wen; end
      advance();
    end
    req_vld = 0;
  endtask

  task automatic wait_rsp(output logic [31:0] d, output bit ok);
    ok = 0; d = '0;
    for (int w = 0; w < 20 && !ok; w++) begin
      sample();
      if (rsp_vld && rsp_rdy) begin ok = 1; d = rsp_data; end
      advance();
    end
  endtask

  initial begin
    logic [31:0] wen, rd;
    bit ok, got;
    int n_acc, first;

    vt[0] = '{0, 11'd0,    32'h0,        4'h0, IVAL};
    vt[1] = '{0, 11'd1024, 32'h0,        4'h0, IVAL};
    vt[2] = '{0, 11'd2047, 32'h0,        4'h0, IVAL};
    vt[3] = '{1, 11'h7FF,  32'h11223344, 4'hF, 32'h00000000};
    vt[4] = '{1, 11'h7FF,  32'hFFFFFFFF, 4'h5, 32'hFF00FF00};
    vt[5] = '{0, 11'h7FF,  32'h0,        4'h0, 32'h11FF33FF};
    vt[6] = '{1, 11'd16,   32'h12345678, 4'h0, 32'hFFFFFFFF};
    vt[7] = '{0, 11'd16,   32'h0,        4'h0, IVAL};

    rst_n = 0; rsp_rdy = 1; rsp_rdy0 = 1;
    req_vld = 0; req_wr = 0; req_addr = '0; req_wdata = '0; req_be = '0;
    req_vld0 = 0; req_wr0 = 0; req_addr0 = '0; req_wdata0 = '0; req_be0 = '0;
    advance();
    repeat (3) tick();
    sample();
    check_idle("rst_idle");
    chk("rst_idle0", {req_rdy0, rsp_vld0, init_done0, ram_cen0, ram_gwen0, ram_wen0, ram_a0, ram_d0},
        {3'b000, 2'b11, 32'hFFFFFFFF, 11'h0, 32'h0});
    advance();
    rst_n = 1;

    // Fill: writes offered during INIT must never be taken
    req_vld = 1; req_wr = 1; req_addr = 11'd3; req_wdata = 32'h0BADF00D; req_be = 4'hF;
    for (int k = 0; k <= 2048; k++) begin
      if (k == 2040) req_vld = 0;
      sample();
      chk($sformatf("init_done_k%0d", k), init_done, (k >= 2048));
      if (k < 4) chk($sformatf("init_done0_k%0d", k), init_done0, (k >= 1));
      if (k == 0 || k == 1000 || k == 2047)
        chk($sformatf("fill_pins_k%0d", k), {ram_cen, ram_gwen, ram_wen, ram_a, ram_d},
            {2'b00, 32'h0, 11'(k), IVAL});
      advance();
    end

    // No-fill instance: write then read back
    req_vld0 = 1; req_wr0 = 1; req_addr0 = 11'd5; req_wdata0 = 32'hDEADBEEF; req_be0 = 4'hF;
    sample(); chk("dut0_wr_rdy", req_rdy0, 1'b1); advance();
    req_wr0 = 0;
    sample(); chk("dut0_rd_rdy", req_rdy0, 1'b1); advance();
    req_vld0 = 0; got = 0;
    for (int w = 0; w < 8; w++) begin
      sample();
      if (!got && rsp_vld0) begin got = 1; chk("dut0_rdata", rsp_data0, 32'hDEADBEEF); end
      advance();
    end
    chk("dut0_rsp_seen", got, 1'b1);

    // Vector table
    foreach (vt[i]) begin
      do_req(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].be, wen, ok);
      chk($sformatf("vec%0d_acc", i), ok, 1'b1);
      if (ok && vt[i].wr) chk($sformatf("vec%0d_wen", i), wen, vt[i].exp);
      if (ok && !vt[i].wr) begin
        wait_rsp(rd, ok);
        chk($sformatf("vec%0d_rsp_seen", i), ok, 1'b1);
        if (ok) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
      end
    end

    // Streaming: 16 back-to-back reads of distinct words
    for (int i = 0; i < 16; i++) begin
      do_req(1, 11'(i), stream_val(i), 4'hF, wen, ok);
      chk("stream_prep_acc", ok, 1'b1);
    end
    for (int c = 0; c < 22; c++) begin
      req_vld = (c < 16); req_wr = 0; req_addr = 11'(c);
      sample();
      if (c < 16) chk($sformatf("stream_rdy_c%0d", c), req_rdy, 1'b1);
      chk($sformatf("stream_vld_c%0d", c), rsp_vld, (c >= 2 && c < 18));
      if (c >= 2 && c < 18) chk($sformatf("stream_data_c%0d", c), rsp_data, stream_val(c - 2));
      advance();
    end
    req_vld = 0;

    // Backpressure: only two reads fit while nothing drains
    rsp_rdy = 0; req_vld = 1; req_wr = 0; n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      req_addr = 11'(20 + n_acc);
      sample();
      if (req_rdy) n_acc++;
      advance();
    end
    chk("bp_accepts", n_acc, 2);
    req_wr = 1; req_addr = 11'd40; req_wdata = 32'h5A5A0001; req_be = 4'hF;
    sample(); chk("bp_wr_rdy", req_rdy, 1'b1); advance();
    req_wr = 0; req_addr = 11'd22; rsp_rdy = 1;
    sample(); chk("bp_pop_vld", rsp_vld, 1'b1); chk("bp_rd_rdy_on_pop", req_rdy, 1'b1); advance();
    rsp_rdy = 0; req_addr = 11'd23;
    sample(); chk("bp_rd_blocked", req_rdy, 1'b0); advance();
    req_vld = 0; rsp_rdy = 1;
    repeat (6) tick();
    chk("bp_drained", exp_q.size(), 0);

    // Random traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      req_vld = ($urandom_range(0, 3) != 0);
      req_wr = 1'($urandom_range(0, 1));
      req_addr = 11'($urandom_range(0, 31));
      req_wdata = $urandom;
      req_be = 4'($urandom);
      rsp_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_vld = 0; rsp_rdy = 1;
    repeat (8) tick();
    chk("rand_drained", exp_q.size(), 0);

    // Reset mid-fill at fill address 500
    rst_n = 0; tick(); rst_n = 1;
    for (int k = 0; k < 500; k++) begin
      sample();
      if (k == 499) chk("midfill_addr", ram_a, 11'd499);
      advance();
    end
    rst_n = 0;
    sample(); check_idle("midfill_rst_idle"); advance();
    rst_n = 1; first = -1;
    for (int k = 0; k < 2100 && first < 0; k++) begin
      sample();
      if (init_done) first = k;
      advance();
    end
    chk("refill_done_cycle", first, 2048);
    do_req(0, 11'd40, 32'h0, 4'h0, wen, ok);
    chk("refill_rd_acc", ok, 1'b1);
    wait_rsp(rd, ok);
    chk("refill_rsp_seen", ok, 1'b1);
    if (ok) chk("refill_rdata", rd, IVAL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
